// File: rtl/mips_regfile_mp_pkg.sv
// Shared defaults and constants for the multi-port MIPS register file.
package mips_regfile_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Number of architectural registers for a given address width.
    function automatic int rf_depth(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/mips_rf_wr_arb.sv
// Write-port collision resolver: for one register address, reports whether
// any enabled write port targets it and which data wins (highest port index).
module mips_rf_wr_arb
    import mips_regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    // Scan ports in ascending order so the last (highest) matching port wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[j*DATA_W +: DATA_W];
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with optional write-to-read bypass and a
// per-register pending scoreboard for decode-stage RAW hazard detection.
module mips_regfile_mp
    import mips_regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [2**ADDR_W-1:0]     pend_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_r     [DEPTH];
    logic [DATA_W-1:0] regs_nxt_s [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [DEPTH-1:0]  pend_nxt_s;

    logic [DEPTH-1:0]  st_hit_s;
    logic [DATA_W-1:0] st_data_s  [DEPTH];
    logic [NUM_RD-1:0] byp_hit_s;
    logic [DATA_W-1:0] byp_data_s [NUM_RD];

    // One resolver per register decides the stored value on collisions.
    for (genvar r = 0; r < DEPTH; r++) begin : g_st_arb
        mips_rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_st_arb (
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .addr_i    (ADDR_W'(r)),
            .hit_o     (st_hit_s[r]),
            .data_o    (st_data_s[r])
        );
    end

    // One resolver per read port supplies same-cycle forwarded data.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_arb
        mips_rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_rd_arb (
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .addr_i    (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .hit_o     (byp_hit_s[k]),
            .data_o    (byp_data_s[k])
        );
    end

    // Next-state storage: register 0 stays zero, others take the winning write.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            if (r == REG_ZERO) begin
                regs_nxt_s[r] = '0;
            end else if (st_hit_s[r]) begin
                regs_nxt_s[r] = st_data_s[r];
            end else begin
                regs_nxt_s[r] = regs_r[r];
            end
        end
    end

    // Next-state scoreboard: issue sets (beats a same-cycle write), write clears.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int r = 0; r < DEPTH; r++) begin
            if (r == REG_ZERO) begin
                pend_nxt_s[r] = 1'b0;
            end else if (iss_en_i && (iss_addr_i == ADDR_W'(r))) begin
                pend_nxt_s[r] = 1'b1;
            end else if (st_hit_s[r]) begin
                pend_nxt_s[r] = 1'b0;
            end else begin
                pend_nxt_s[r] = pend_r[r];
            end
        end
    end

    // Register storage and pending bits; reset clears both asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r <= '{default: '0};
            pend_r <= '0;
        end else begin
            regs_r <= regs_nxt_s;
            pend_r <= pend_nxt_s;
        end
    end

    // Read ports: zero register, then forwarded write, then stored state.
    always_comb begin
        logic [ADDR_W-1:0] ra_s;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_s = rd_addr_i[k*ADDR_W +: ADDR_W];
            if (ra_s == ADDR_W'(REG_ZERO)) begin
                rd_data_o[k*DATA_W +: DATA_W] = '0;
                rd_busy_o[k]                  = 1'b0;
            end else if ((BYPASS != 0) && byp_hit_s[k]) begin
                rd_data_o[k*DATA_W +: DATA_W] = byp_data_s[k];
                rd_busy_o[k]                  = 1'b0;
            end else begin
                rd_data_o[k*DATA_W +: DATA_W] = regs_r[ra_s];
                rd_busy_o[k]                  = pend_r[ra_s];
            end
        end
    end

    assign pend_o = pend_r;

endmodule
